// File: rtl/rv32i_exec_mem_unit_if.sv
// ----------------------------------------------------------------------------
// rv32i_exec_mem_unit_if
// Operand/result bundle between the register file / PC logic and the
// RV32I execute/memory slice.
//   i_instr       instruction word
//   i_pc          address of i_instr
//   i_rs1_data    value of register instr[19:15]
//   i_rs2_data    value of register instr[24:20]
//   o_rd_addr     destination register (instr[11:7])
//   o_reg_write   write-back enable
//   o_wb_data     write-back value
//   o_pc_next     next fetch address
//   o_branch_taken control transfer (taken branch, jal, jalr)
//   o_illegal     sticky unsupported-instruction flag
// slave modport: the execute unit; master modport: the driving core/bench.
// ----------------------------------------------------------------------------
interface rv32i_exec_mem_unit_if #(
  parameter int XLEN = 32
);
  logic [XLEN-1:0] i_instr;
  logic [XLEN-1:0] i_pc;
  logic [XLEN-1:0] i_rs1_data;
  logic [XLEN-1:0] i_rs2_data;
  logic [4:0]      o_rd_addr;
  logic            o_reg_write;
  logic [XLEN-1:0] o_wb_data;
  logic [XLEN-1:0] o_pc_next;
  logic            o_branch_taken;
  logic            o_illegal;

  modport slave (
    input  i_instr, i_pc, i_rs1_data, i_rs2_data,
    output o_rd_addr, o_reg_write, o_wb_data, o_pc_next, o_branch_taken, o_illegal
  );

  modport master (
    output i_instr, i_pc, i_rs1_data, i_rs2_data,
    input  o_rd_addr, o_reg_write, o_wb_data, o_pc_next, o_branch_taken, o_illegal
  );
endinterface

// File: rtl/rv32i_exec_mem_unit.sv
// ----------------------------------------------------------------------------
// rv32i_exec_mem_unit
// RV32I execute/memory slice: decode, immediate generation, ALU with branch
// compare and a byte-addressed little-endian data memory of 2**DMEM_AW bytes.
// Everything is combinational from the inputs and memory contents except the
// store (commits on rising clk) and the sticky illegal flag.
// Ports:
//   clk  clock; stores commit on the rising edge
//   rst  synchronous active-high reset; blocks the store, clears illegal
//   bus  rv32i_exec_mem_unit_if.slave (instr/pc/operands in, results out)
// Parameters: DMEM_AW (memory address width in bytes), XLEN (fixed 32).
// Build option: define MISALIGN_TRAP_EN to trap misaligned lh/lhu/sh/lw/sw
// (no store, no write-back, sets illegal); otherwise they complete bytewise.
// ----------------------------------------------------------------------------
module rv32i_exec_mem_unit #(
  parameter int DMEM_AW = 12,
  parameter int XLEN    = 32
) (
  input logic                  clk,
  input logic                  rst,
  rv32i_exec_mem_unit_if.slave bus
);

  typedef enum logic [6:0] {
    OPC_LOAD   = 7'b0000011,
    OPC_OPIMM  = 7'b0010011,
    OPC_AUIPC  = 7'b0010111,
    OPC_STORE  = 7'b0100011,
    OPC_OP     = 7'b0110011,
    OPC_LUI    = 7'b0110111,
    OPC_BRANCH = 7'b1100011,
    OPC_JALR   = 7'b1100111,
    OPC_JAL    = 7'b1101111
  } opcode_e;

  typedef enum logic [3:0] {
    ALU_ADD  = 4'b0000,
    ALU_SUB  = 4'b0001,
    ALU_AND  = 4'b0010,
    ALU_OR   = 4'b0011,
    ALU_XOR  = 4'b0100,
    ALU_SLL  = 4'b0101,
    ALU_SRL  = 4'b0110,
    ALU_SRA  = 4'b0111,
    ALU_SLT  = 4'b1000,
    ALU_SLTU = 4'b1001,
    ALU_PASSB = 4'b1010
  } alu_e;

  typedef enum logic [3:0] {
    MEM_LB   = 4'b0000,
    MEM_LH   = 4'b0001,
    MEM_LW   = 4'b0010,
    MEM_LBU  = 4'b0100,
    MEM_LHU  = 4'b0101,
    MEM_IDLE = 4'b1000,
    MEM_SB   = 4'b1001,
    MEM_SH   = 4'b1010,
    MEM_SW   = 4'b1011
  } mem_e;

  logic [7:0] r_mem [0:(1<<DMEM_AW)-1];
  logic       r_illegal;

  logic [6:0]      w_opc;
  logic [2:0]      w_f3;
  logic [4:0]      w_rd;
  logic            w_lui, w_auipc, w_jal, w_jalr, w_branch, w_load, w_store, w_opimm, w_op;
  logic            w_supported;
  logic [XLEN-1:0] w_imm_i, w_imm_s, w_imm_b, w_imm_u, w_imm_j;
  logic [XLEN-1:0] w_alu_a, w_alu_b, w_alu_y;
  alu_e            w_alu_ctrl;
  logic            w_br_cond, w_br_f3_ok;
  mem_e            w_mem_mode;
  logic            w_mem_f3_ok;
  logic            w_half, w_word;
  logic [DMEM_AW-1:0] w_addr0, w_addr1, w_addr2, w_addr3;
  logic [7:0]      w_b0, w_b1, w_b2, w_b3;
  logic [XLEN-1:0] w_load_data;
  logic            w_trap;
  logic            w_illegal_now;
  logic            w_store_en;
  logic [XLEN-1:0] w_pc_plus4;

  assign w_opc = bus.i_instr[6:0];
  assign w_f3  = bus.i_instr[14:12];
  assign w_rd  = bus.i_instr[11:7];

  assign w_lui    = (w_opc == OPC_LUI);
  assign w_auipc  = (w_opc == OPC_AUIPC);
  assign w_jal    = (w_opc == OPC_JAL);
  assign w_jalr   = (w_opc == OPC_JALR);
  assign w_branch = (w_opc == OPC_BRANCH);
  assign w_load   = (w_opc == OPC_LOAD);
  assign w_store  = (w_opc == OPC_STORE);
  assign w_opimm  = (w_opc == OPC_OPIMM);
  assign w_op     = (w_opc == OPC_OP);
  assign w_supported = w_lui | w_auipc | w_jal | w_jalr | w_branch |
                       w_load | w_store | w_opimm | w_op;

  assign w_imm_i = {{20{bus.i_instr[31]}}, bus.i_instr[31:20]};
  assign w_imm_s = {{20{bus.i_instr[31]}}, bus.i_instr[31:25], bus.i_instr[11:7]};
  assign w_imm_b = {{19{bus.i_instr[31]}}, bus.i_instr[31], bus.i_instr[7],
                    bus.i_instr[30:25], bus.i_instr[11:8], 1'b0};
  assign w_imm_u = {bus.i_instr[31:12], 12'b0};
  assign w_imm_j = {{11{bus.i_instr[31]}}, bus.i_instr[31], bus.i_instr[19:12],
                    bus.i_instr[20], bus.i_instr[30:21], 1'b0};

  assign w_alu_a = w_auipc ? bus.i_pc : bus.i_rs1_data;

  always_comb begin
    if (w_op || w_branch)       w_alu_b = bus.i_rs2_data;
    else if (w_store)           w_alu_b = w_imm_s;
    else if (w_lui || w_auipc)  w_alu_b = w_imm_u;
    else                        w_alu_b = w_imm_i;
  end

  // instr[30] selects sub only for register-register ops; for shifts it picks
  // arithmetic right shift in both OP and OP-IMM forms.
  always_comb begin
    w_alu_ctrl = ALU_ADD;
    if (w_lui) begin
      w_alu_ctrl = ALU_PASSB;
    end else if (w_op || w_opimm) begin
      case (w_f3)
        3'b000: if (w_op && bus.i_instr[30]) w_alu_ctrl = ALU_SUB;
                else                         w_alu_ctrl = ALU_ADD;
        3'b001: w_alu_ctrl = ALU_SLL;
        3'b010: w_alu_ctrl = ALU_SLT;
        3'b011: w_alu_ctrl = ALU_SLTU;
        3'b100: w_alu_ctrl = ALU_XOR;
        3'b101: if (bus.i_instr[30]) w_alu_ctrl = ALU_SRA;
                else                 w_alu_ctrl = ALU_SRL;
        3'b110: w_alu_ctrl = ALU_OR;
        default: w_alu_ctrl = ALU_AND;
      endcase
    end
  end

  always_comb begin
    case (w_alu_ctrl)
      ALU_SUB:   w_alu_y = w_alu_a - w_alu_b;
      ALU_AND:   w_alu_y = w_alu_a & w_alu_b;
      ALU_OR:    w_alu_y = w_alu_a | w_alu_b;
      ALU_XOR:   w_alu_y = w_alu_a ^ w_alu_b;
      ALU_SLL:   w_alu_y = w_alu_a << w_alu_b[4:0];
      ALU_SRL:   w_alu_y = w_alu_a >> w_alu_b[4:0];
      ALU_SRA:   w_alu_y = $unsigned($signed(w_alu_a) >>> w_alu_b[4:0]);
      ALU_SLT:   w_alu_y = {{(XLEN-1){1'b0}}, $signed(w_alu_a) < $signed(w_alu_b)};
      ALU_SLTU:  w_alu_y = {{(XLEN-1){1'b0}}, w_alu_a < w_alu_b};
      ALU_PASSB: w_alu_y = w_alu_b;
      default:   w_alu_y = w_alu_a + w_alu_b;
    endcase
  end

  always_comb begin
    w_br_cond  = 1'b0;
    w_br_f3_ok = 1'b1;
    case (w_f3)
      3'b000: w_br_cond = (w_alu_a == w_alu_b);
      3'b001: w_br_cond = (w_alu_a != w_alu_b);
      3'b100: w_br_cond = ($signed(w_alu_a) <  $signed(w_alu_b));
      3'b101: w_br_cond = ($signed(w_alu_a) >= $signed(w_alu_b));
      3'b110: w_br_cond = (w_alu_a <  w_alu_b);
      3'b111: w_br_cond = (w_alu_a >= w_alu_b);
      default: w_br_f3_ok = 1'b0;
    endcase
  end

  always_comb begin
    w_mem_mode  = MEM_IDLE;
    w_mem_f3_ok = 1'b1;
    if (w_load) begin
      case (w_f3)
        3'b000: w_mem_mode = MEM_LB;
        3'b001: w_mem_mode = MEM_LH;
        3'b010: w_mem_mode = MEM_LW;
        3'b100: w_mem_mode = MEM_LBU;
        3'b101: w_mem_mode = MEM_LHU;
        default: w_mem_f3_ok = 1'b0;
      endcase
    end else if (w_store) begin
      case (w_f3)
        3'b000: w_mem_mode = MEM_SB;
        3'b001: w_mem_mode = MEM_SH;
        3'b010: w_mem_mode = MEM_SW;
        default: w_mem_f3_ok = 1'b0;
      endcase
    end
  end

  assign w_half = (w_mem_mode == MEM_LH) || (w_mem_mode == MEM_LHU) || (w_mem_mode == MEM_SH);
  assign w_word = (w_mem_mode == MEM_LW) || (w_mem_mode == MEM_SW);

  // Byte addresses are DMEM_AW bits wide, so multi-byte accesses wrap on their own.
  assign w_addr0 = w_alu_y[DMEM_AW-1:0];
  assign w_addr1 = w_addr0 + DMEM_AW'(1);
  assign w_addr2 = w_addr0 + DMEM_AW'(2);
  assign w_addr3 = w_addr0 + DMEM_AW'(3);

  assign w_b0 = r_mem[w_addr0];
  assign w_b1 = r_mem[w_addr1];
  assign w_b2 = r_mem[w_addr2];
  assign w_b3 = r_mem[w_addr3];

  always_comb begin
    case (w_mem_mode)
      MEM_LB:  w_load_data = {{24{w_b0[7]}}, w_b0};
      MEM_LH:  w_load_data = {{16{w_b1[7]}}, w_b1, w_b0};
      MEM_LW:  w_load_data = {w_b3, w_b2, w_b1, w_b0};
      MEM_LBU: w_load_data = {24'b0, w_b0};
      MEM_LHU: w_load_data = {16'b0, w_b1, w_b0};
      default: w_load_data = '0;
    endcase
  end

`ifdef MISALIGN_TRAP_EN
  assign w_trap = (w_half && w_addr0[0]) || (w_word && (w_addr0[1:0] != 2'b00));
`else
  assign w_trap = 1'b0;
`endif

  assign w_illegal_now = !w_supported ||
                         (w_branch && !w_br_f3_ok) ||
                         ((w_load || w_store) && !w_mem_f3_ok) ||
                         w_trap;

  assign w_store_en = w_store && !w_illegal_now;

  always_ff @(posedge clk) begin
    if (!rst && w_store_en) begin
      r_mem[w_addr0] <= bus.i_rs2_data[7:0];
      if (w_half || w_word) r_mem[w_addr1] <= bus.i_rs2_data[15:8];
      if (w_word) begin
        r_mem[w_addr2] <= bus.i_rs2_data[23:16];
        r_mem[w_addr3] <= bus.i_rs2_data[31:24];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst)                r_illegal <= 1'b0;
    else if (w_illegal_now) r_illegal <= 1'b1;
  end

  assign w_pc_plus4 = bus.i_pc + 32'd4;

  assign bus.o_rd_addr   = w_rd;
  assign bus.o_illegal   = r_illegal;
  assign bus.o_reg_write = (w_lui || w_auipc || w_jal || w_jalr || w_load || w_opimm || w_op) &&
                           !w_illegal_now && (w_rd != 5'd0);
  assign bus.o_branch_taken = !w_illegal_now && (w_jal || w_jalr || (w_branch && w_br_cond));

  always_comb begin
    if (w_jal || w_jalr) bus.o_wb_data = w_pc_plus4;
    else if (w_load)     bus.o_wb_data = w_load_data;
    else                 bus.o_wb_data = w_alu_y;
  end

  always_comb begin
    if (w_jal)                                        bus.o_pc_next = bus.i_pc + w_imm_j;
    else if (w_jalr)                                  bus.o_pc_next = {w_alu_y[XLEN-1:1], 1'b0};
    else if (w_branch && w_br_f3_ok && w_br_cond)     bus.o_pc_next = bus.i_pc + w_imm_b;
    else                                              bus.o_pc_next = w_pc_plus4;
  end

endmodule

// File: tb/tb_rv32i_exec_mem_unit.sv
// ----------------------------------------------------------------------------
// tb_rv32i_exec_mem_unit
// Self-checking bench: an instruction-level reference model (plain ISA
// semantics over a byte array) is compared against the DUT on every cycle,
// plus directed instructions with hand-computed expected values.
// ----------------------------------------------------------------------------
module tb_rv32i_exec_mem_unit;
  localparam int AW    = 12;
  localparam int MSIZE = 1 << AW;
  localparam logic [31:0] NOP = 32'h0000_0013;

  typedef struct {
    logic [4:0]  rd;
    bit          rw;
    logic [31:0] wb;
    logic [31:0] pcn;
    bit          taken;
    bit          ill;
    bit          st;
    int unsigned st_addr;
    int unsigned st_n;
    logic [31:0] st_val;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  rv32i_exec_mem_unit_if #(.XLEN(32)) bus ();

  rv32i_exec_mem_unit #(.DMEM_AW(AW), .XLEN(32)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int unsigned n_checks = 0;
  int unsigned n_fail   = 0;
  bit          started  = 1'b0;
  logic [7:0]  mm [MSIZE];
  bit          ill_m    = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Instruction-level semantics straight from the ISA rules.
  function automatic exp_t model(input logic [31:0] ins, input logic [31:0] pc,
                                 input logic [31:0] a, input logic [31:0] b);
    exp_t e;
    logic [31:0] immI, immS, immB, immU, immJ, bb, v;
    logic [2:0]  f3;
    int unsigned ad, n;
    bit          sgn, t;
    e = '{rd: ins[11:7], rw: 0, wb: '0, pcn: pc + 32'd4, taken: 0, ill: 0,
          st: 0, st_addr: 0, st_n: 0, st_val: '0};
    f3   = ins[14:12];
    immI = {{20{ins[31]}}, ins[31:20]};
    immS = {{20{ins[31]}}, ins[31:25], ins[11:7]};
    immB = {{19{ins[31]}}, ins[31], ins[7], ins[30:25], ins[11:8], 1'b0};
    immU = {ins[31:12], 12'b0};
    immJ = {{11{ins[31]}}, ins[31], ins[19:12], ins[20], ins[30:21], 1'b0};
    n = 0; sgn = 0; t = 0;
    case (ins[6:0])
      7'h37: begin e.rw = 1; e.wb = immU; end
      7'h17: begin e.rw = 1; e.wb = pc + immU; end
      7'h6F: begin e.rw = 1; e.wb = pc + 4; e.pcn = pc + immJ; e.taken = 1; end
      7'h67: begin e.rw = 1; e.wb = pc + 4; e.pcn = (a + immI) & ~32'h1; e.taken = 1; end
      7'h63: begin
        case (f3)
          3'd0: t = (a == b);
          3'd1: t = (a != b);
          3'd4: t = ($signed(a) <  $signed(b));
          3'd5: t = ($signed(a) >= $signed(b));
          3'd6: t = (a <  b);
          3'd7: t = (a >= b);
          default: e.ill = 1;
        endcase
        if (!e.ill && t) begin e.taken = 1; e.pcn = pc + immB; end
      end
      7'h03: begin
        ad = (a + immI) % MSIZE;
        case (f3)
          3'd0: begin n = 1; sgn = 1; end
          3'd1: begin n = 2; sgn = 1; end
          3'd2: n = 4;
          3'd4: n = 1;
          3'd5: n = 2;
          default: e.ill = 1;
        endcase
`ifdef MISALIGN_TRAP_EN
        if (n > 1 && (ad % n) != 0) e.ill = 1;
`endif
        if (!e.ill) begin
          v = '0;
          for (int k = 0; k < int'(n); k++) v = v | (32'(mm[(ad + k) % MSIZE]) << (8 * k));
          if (sgn && n == 1) v = {{24{v[7]}}, v[7:0]};
          if (sgn && n == 2) v = {{16{v[15]}}, v[15:0]};
          e.rw = 1; e.wb = v;
        end
      end
      7'h23: begin
        ad = (a + immS) % MSIZE;
        case (f3)
          3'd0: n = 1;
          3'd1: n = 2;
          3'd2: n = 4;
          default: e.ill = 1;
        endcase
`ifdef MISALIGN_TRAP_EN
        if (n > 1 && (ad % n) != 0) e.ill = 1;
`endif
        if (!e.ill) begin e.st = 1; e.st_addr = ad; e.st_n = n; e.st_val = b; end
      end
      7'h13, 7'h33: begin
        bb = (ins[6:0] == 7'h33) ? b : immI;
        e.rw = 1;
        case (f3)
          3'd0: if (ins[6:0] == 7'h33 && ins[30]) e.wb = a - bb; else e.wb = a + bb;
          3'd1: e.wb = a << bb[4:0];
          3'd2: e.wb = ($signed(a) < $signed(bb)) ? 32'd1 : 32'd0;
          3'd3: e.wb = (a < bb) ? 32'd1 : 32'd0;
          3'd4: e.wb = a ^ bb;
          3'd5: if (ins[30]) e.wb = $unsigned($signed(a) >>> bb[4:0]); else e.wb = a >> bb[4:0];
          3'd6: e.wb = a | bb;
          default: e.wb = a & bb;
        endcase
      end
      default: e.ill = 1;
    endcase
    if (e.ill) begin e.rw = 0; e.taken = 0; e.pcn = pc + 32'd4; e.st = 0; end
    if (e.rd == 5'd0) e.rw = 0;
    return e;
  endfunction

  // Reference state update at each rising edge.
  exp_t eu;
  always @(posedge clk) begin
    if (started) begin
      eu = model(bus.i_instr, bus.i_pc, bus.i_rs1_data, bus.i_rs2_data);
      if (rst) ill_m = 1'b0;
      else begin
        if (eu.ill) ill_m = 1'b1;
        if (eu.st)
          for (int k = 0; k < int'(eu.st_n); k++)
            mm[(eu.st_addr + k) % MSIZE] = eu.st_val[8*k +: 8];
      end
    end
  end

  // Every-cycle comparison against the model, away from the active edge.
  exp_t ec;
  always @(negedge clk) begin
    if (started) begin
      ec = model(bus.i_instr, bus.i_pc, bus.i_rs1_data, bus.i_rs2_data);
      chk("rd_addr",      32'(bus.o_rd_addr),      32'(ec.rd));
      chk("reg_write",    32'(bus.o_reg_write),    32'(ec.rw));
      if (ec.rw) chk("wb_data", bus.o_wb_data, ec.wb);
      chk("pc_next",      bus.o_pc_next,           ec.pcn);
      chk("branch_taken", 32'(bus.o_branch_taken), 32'(ec.taken));
      chk("illegal",      32'(bus.o_illegal),      32'(ill_m));
    end
  end

  task automatic drive(input logic [31:0] ins, input logic [31:0] pc,
                       input logic [31:0] a, input logic [31:0] b, input bit r);
    @(posedge clk);
    #1;
    bus.i_instr = ins; bus.i_pc = pc; bus.i_rs1_data = a; bus.i_rs2_data = b; rst = r;
  endtask

  logic [31:0] ops [9] = '{32'h37, 32'h17, 32'h6F, 32'h67, 32'h63, 32'h03, 32'h23, 32'h13, 32'h33};
  logic [7:0]  saved_b;

  initial begin
    bus.i_instr = NOP; bus.i_pc = '0; bus.i_rs1_data = '0; bus.i_rs2_data = '0;
    rst = 1'b1;
    for (int i = 0; i < MSIZE; i++) mm[i] = '0;
    started = 1'b1;
    drive(NOP, 0, 0, 0, 1);
    drive(NOP, 0, 0, 0, 0);
    @(negedge clk);
    chk("reset_illegal", 32'(bus.o_illegal), 32'd0);

    // Fill the whole memory with known words so every later load is predictable.
    for (int i = 0; i < MSIZE / 4; i++) drive(32'h0020A023, 32'(i * 4), 32'(i * 4), $urandom, 0);

    drive(32'h002081B3, 32'h100, 32'd5, 32'hFFFF_FFFE, 0);  // add x3,x1,x2
    @(negedge clk);
    chk("add_wb", bus.o_wb_data, 32'd3);
    chk("add_rw", 32'(bus.o_reg_write), 32'd1);
    chk("add_rd", 32'(bus.o_rd_addr), 32'd3);
    chk("add_pcn", bus.o_pc_next, 32'h104);

    drive(32'h0020A223, 32'h104, 32'h100, 32'h80FF_1234, 0); // sw x2,4(x1)
    drive(32'h00708283, 32'h108, 32'h100, 32'h0, 0);         // lb x5,7(x1)
    @(negedge clk);
    chk("lb_0x107", bus.o_wb_data, 32'hFFFF_FF80);
    drive(32'h0070C283, 32'h10C, 32'h100, 32'h0, 0);         // lbu x5,7(x1)
    @(negedge clk);
    chk("lbu_0x107", bus.o_wb_data, 32'h0000_0080);
    drive(32'h0040D283, 32'h110, 32'h100, 32'h0, 0);         // lhu x5,4(x1)
    @(negedge clk);
    chk("lhu_0x104", bus.o_wb_data, 32'h0000_1234);

    drive(32'hFE208CE3, 32'h20, 32'd7, 32'd7, 0);            // beq -8
    @(negedge clk);
    chk("beq_pcn", bus.o_pc_next, 32'h18);
    chk("beq_taken", 32'(bus.o_branch_taken), 32'd1);
    drive(32'hFE20ECE3, 32'h20, 32'd1, 32'hFFFF_FFFF, 0);    // bltu
    @(negedge clk);
    chk("bltu_taken", 32'(bus.o_branch_taken), 32'd1);
    chk("bltu_pcn", bus.o_pc_next, 32'h18);
    drive(32'hFE20CCE3, 32'h20, 32'd1, 32'hFFFF_FFFF, 0);    // blt
    @(negedge clk);
    chk("blt_taken", 32'(bus.o_branch_taken), 32'd0);
    chk("blt_pcn", bus.o_pc_next, 32'h24);

    drive(32'h003280E7, 32'h40, 32'h200, 32'h0, 0);          // jalr x1,3(x5)
    @(negedge clk);
    chk("jalr_pcn", bus.o_pc_next, 32'h202);
    chk("jalr_wb", bus.o_wb_data, 32'h44);
    drive(32'h123450B7, 32'h44, 32'h0, 32'h0, 0);            // lui x1,0x12345
    @(negedge clk);
    chk("lui_wb", bus.o_wb_data, 32'h1234_5000);
    drive(32'h00001097, 32'h10, 32'h0, 32'h0, 0);            // auipc x1,1
    @(negedge clk);
    chk("auipc_wb", bus.o_wb_data, 32'h1010);

    drive(32'h0020A223, 32'h50, 32'h100, 32'hDEAD_BEEF, 1);  // sw under reset
    drive(32'h0040A283, 32'h54, 32'h100, 32'h0, 0);          // lw x5,4(x1)
    @(negedge clk);
    chk("sw_in_reset", bus.o_wb_data, 32'h80FF_1234);

    drive(32'h0000007F, 32'h58, 32'h0, 32'h0, 0);
    @(negedge clk);
    chk("illegal_pre_edge", 32'(bus.o_illegal), 32'd0);
    chk("illegal_rw", 32'(bus.o_reg_write), 32'd0);
    drive(NOP, 32'h5C, 0, 0, 0);
    @(negedge clk);
    chk("illegal_set", 32'(bus.o_illegal), 32'd1);
    drive(NOP, 32'h60, 0, 0, 1);
    drive(NOP, 32'h64, 0, 0, 0);
    @(negedge clk);
    chk("illegal_cleared", 32'(bus.o_illegal), 32'd0);

    saved_b = mm[12'hFFE];
    drive(32'h0020A023, 32'h68, 32'hFFE, 32'hA1B2_C3D4, 0);  // sw x2,0(x1) @0xFFE
`ifndef MISALIGN_TRAP_EN
    drive(32'h0000A283, 32'h6C, 32'hFFE, 32'h0, 0);          // lw @0xFFE
    @(negedge clk);
    chk("wrap_lw", bus.o_wb_data, 32'hA1B2_C3D4);
    drive(32'h0000C283, 32'h70, 32'h0, 32'h0, 0);            // lbu @0x000
    @(negedge clk);
    chk("wrap_lbu0", bus.o_wb_data, 32'hB2);
    drive(32'h0000C283, 32'h74, 32'hFFF, 32'h0, 0);          // lbu @0xFFF
    @(negedge clk);
    chk("wrap_lbuFFF", bus.o_wb_data, 32'hC3);
`else
    drive(32'h0000C283, 32'h6C, 32'hFFE, 32'h0, 0);          // lbu @0xFFE
    @(negedge clk);
    chk("trap_illegal", 32'(bus.o_illegal), 32'd1);
    chk("trap_no_store", bus.o_wb_data, 32'(saved_b));
    drive(32'h0000A283, 32'h70, 32'hFFE, 32'h0, 0);          // misaligned lw
    @(negedge clk);
    chk("trap_lw_rw", 32'(bus.o_reg_write), 32'd0);
`endif

    drive(NOP, 0, 0, 0, 1);
    for (int i = 0; i < 3000; i++) begin
      logic [31:0] ins, a;
      int unsigned sel;
      sel = $urandom_range(0, 9);
      ins = $urandom;
      if (sel < 9) ins[6:0] = ops[sel][6:0];
      a = $urandom;
      if ($urandom_range(0, 1) == 0) a[1:0] = 2'b00;
      drive(ins, $urandom, a, $urandom, $urandom_range(0, 19) == 0);
    end

    drive(NOP, 0, 0, 0, 0);
    @(negedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/rv32i_exec_mem_unit.md
Name: rv32i_exec_mem_unit

Overview:
- RV32I execute/memory slice for single-issue cores: instruction decode, immediate generation, ALU with branch compare, and byte-addressed little-endian data memory.
- Takes a 32-bit instruction plus register operands and PC. Produces the register write-back value, destination, next PC and a memory side-effect.
- Sits between the register file and the PC logic.

Parameters:
- DMEM_AW, 12, data memory address width in bytes (4 KiB); higher address bits ignored, so addresses wrap.
- XLEN, 32, datapath width; fixed at 32.

Ports:
- clk  in  1  clock; store commits on rising edge
- rst  in  1  synchronous reset, active-high
- instr  in  32  instruction word
- pc  in  32  address of instr
- rs1_data  in  32  value of register instr[19:15]
- rs2_data  in  32  value of register instr[24:20]
- rd_addr  out  5  instr[11:7]
- reg_write  out  1  write-back enable
- wb_data  out  32  write-back value
- pc_next  out  32  next fetch address
- branch_taken  out  1  control transfer (taken branch, jal or jalr)
- illegal  out  1  sticky unsupported-opcode flag

Behaviour:
- One clock; reset is synchronous and active-high.
- Decode, ALU, load read, wb_data and pc_next are combinational from inputs and memory contents. Stores write memory at the rising clk edge.
- Reset:
  - rst=1 suppresses any store that edge.
  - Clears illegal to 0 on the next edge.
  - Memory contents are not cleared.
- Supported opcodes: LUI, AUIPC, JAL, JALR, BRANCH, LOAD, STORE, OP-IMM, OP. Any other opcode gives reg_write=0, no store, pc_next=pc+4, and sets illegal (sticky until rst).
- Immediates are sign-extended: I, S, B (bit0=0), U (low 12 zero), J (bit0=0).
- ALU operand A is rs1_data, or pc for AUIPC. Operand B is rs2_data for OP and BRANCH, otherwise the immediate.
- ALU control codes (4-bit):
  - 0000 add, 0001 sub, 0010 and, 0011 or, 0100 xor
  - 0101 sll, 0110 srl, 0111 sra
  - 1000 slt, 1001 sltu, 1010 pass B (LUI)
- Shift amounts use B[4:0]. slt/sltu results are 0 or 1.
- Branch condition: beq a==b, bne a!=b, blt/bge signed, bltu/bgeu unsigned. Funct3 010/011 is treated as illegal.
- pc_next:
  - jal: pc+immJ
  - taken branch: pc+immB
  - jalr: (rs1_data+immI) with bit0 cleared
  - otherwise: pc+4
- wb_data: pc+4 for jal/jalr, load data for LOAD, otherwise the ALU result.
- reg_write=0 for BRANCH/STORE/illegal and when rd_addr=0.
- Memory access mode is a 4-bit code:
  - 1000 = idle (all non-memory instructions)
  - Loads: 0000 lb, 0001 lh, 0010 lw, 0100 lbu, 0101 lhu
  - Stores: 1001 sb, 1010 sh, 1011 sw
  - Unknown load/store funct3 is treated as illegal.
- Address = ALU result (rs1+imm) modulo 2^DMEM_AW. Multi-byte accesses wrap byte-by-byte past the top address.
- Loads: signed loads sign-extend, unsigned loads zero-extend.
- Stores write only the addressed bytes, taken from the low bytes of rs2_data.
- Default: misaligned accesses are performed bytewise (no trap).

Optional Feature:
- Macro MISALIGN_TRAP_EN. When defined, a misaligned access (lh/lhu/sh with addr[0]=1; lw/sw with addr[1:0]!=0) suppresses the store and suppresses reg_write, and sets illegal (sticky).
- When undefined, misaligned accesses complete bytewise as above.

Test Plan:
- add x3,x1,x2 with rs1=5, rs2=0xFFFFFFFE -> wb_data=3, reg_write=1, rd_addr=3, pc_next=pc+4.
- sw x2,4(x1) with rs1=0x100, rs2=0x80FF1234, then lb from 0x107 -> 0xFFFFFF80; lbu from 0x107 -> 0x80; lhu from 0x104 -> 0x1234.
- beq with equal operands at pc=0x20, imm=-8 -> pc_next=0x18, branch_taken=1. bltu 1 vs 0xFFFFFFFF -> taken. blt 1 vs 0xFFFFFFFF -> not taken.
- jalr x1,3(x5) with rs1=0x200 at pc=0x40 -> pc_next=0x202, wb_data=0x44. lui 0x12345 -> wb_data=0x12345000. auipc 1 at pc=0x10 -> 0x1010.
- sw asserted with rst=1 -> memory unchanged. Opcode 0x7F -> illegal=1 after the edge, cleared after an rst edge.
- sw to address 0xFFE with DMEM_AW=12 -> bytes land at 0xFFE, 0xFFF, 0x000, 0x001; lw at 0xFFE returns the same word. With MISALIGN_TRAP_EN defined, no write occurs and illegal=1.
